ifetch_axi_lite_master: RTL
===========================

Name: ifetch_axi_lite_master

Overview:
AXI4-Lite read-only initiator that sits between the core's fetch stage and the instruction-memory AXI4-Lite read slave. It accepts one fetch request at a time from the core and issues exactly one AR transaction per request. It collects the R beat and returns the instruction word to the core as a single-cycle pulse. It also supports flush (redirect) discard, misaligned-address rejection and a bus timeout.

Parameters:
ADDR_WIDTH, 32, AXI and fetch address width
DATA_WIDTH, 32, AXI and instruction data width
TIMEOUT_CYCLES, 256, cycles spent in ADDR+DATA before the transaction is abandoned; must be >=2
CNT_WIDTH, 9, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
i_fetch_req  in  1  core fetch request, sampled only while o_fetch_ready=1
i_fetch_addr  in  ADDR_WIDTH  byte address of the instruction
o_fetch_ready  out  1  block is idle and can accept a request
o_fetch_valid  out  1  one-cycle pulse: o_fetch_instr is valid
o_fetch_instr  out  DATA_WIDTH  returned instruction word
o_fetch_err  out  1  one-cycle pulse: misaligned request or timeout
i_flush  in  1  discard the in-flight fetch result
o_axi_araddr  out  ADDR_WIDTH  read address
o_axi_arvalid  out  1  read address valid
i_axi_arready  in  1  read address ready
i_axi_rdata  in  DATA_WIDTH  read data
i_axi_rvalid  in  1  read data valid
o_axi_rready  out  1  read data ready

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - o_axi_araddr, o_axi_arvalid, o_axi_rready, o_fetch_valid, o_fetch_instr, o_fetch_err, discard flag and timeout counter all 0.
  - o_fetch_ready=1 once reset is released.
- Reset mid-transaction returns to IDLE with all of the above cleared. No pending result is ever reported afterwards.
- All outputs are registered. o_fetch_ready is the exception: it is decoded as (state==IDLE).
- o_fetch_valid and o_fetch_err default to 0 every cycle and are set for exactly one cycle. They are never asserted together.
- States: IDLE, ADDR, DATA.
- IDLE, on i_fetch_req=1:
  - If i_fetch_addr[1:0]!=0: no bus access; o_fetch_err=1 next cycle; stay in IDLE.
  - Otherwise: o_axi_araddr<=i_fetch_addr, o_axi_arvalid<=1, timeout counter<=0, discard<=0, go to ADDR.
- ADDR:
  - o_axi_arvalid is held at 1 and o_axi_araddr is held stable until the cycle in which arvalid&&arready are both 1.
  - On that cycle: o_axi_arvalid<=0, o_axi_rready<=1, go to DATA.
- DATA:
  - o_axi_rready is held at 1 until rvalid&&rready.
  - On that cycle: o_axi_rready<=0, go to IDLE.
  - If discard=0: o_fetch_instr<=i_axi_rdata and o_fetch_valid<=1.
  - If discard=1: data is dropped, o_fetch_instr keeps its previous value, and discard<=0.
- o_axi_araddr stays stable from AR issue until the R handshake completes. The memory slave indexes its array directly from araddr after accepting it, so changing it early corrupts the returned word.
- The block never has more than one outstanding transaction and never asserts arvalid and rready at the same time.
- Flush:
  - i_flush=1 in ADDR or DATA sets discard<=1. The AXI transaction still runs to completion, because AR cannot be withdrawn once it is valid.
  - i_flush=1 in IDLE has no effect. A request in the same cycle is accepted normally.
  - i_flush coinciding with the R handshake drops that beat.
- Timeout:
  - The counter increments every cycle in ADDR or DATA.
  - If it reaches TIMEOUT_CYCLES-1 without a handshake completing: arvalid<=0, rready<=0, o_fetch_err<=1 (suppressed if discard=1), go to IDLE.
  - Handshake completion wins over timeout in the same cycle.
- Latency: request to o_fetch_valid = 3 cycles plus slave wait cycles. Against the team imem slave (arready one cycle after arvalid, rvalid one cycle after rready) the latency is 5 cycles.
- Back-to-back: a new request is accepted in the first IDLE cycle after a completion, i.e. the cycle in which o_fetch_valid is high.

Test Plan:
- Reset, then req addr 0x0000_0010 against the imem slave with word[4]=0xDEADBEEF -> araddr=0x10 for 2 cycles, o_fetch_valid pulse 5 cycles after req, o_fetch_instr=0xDEADBEEF, o_fetch_err=0.
- Four back-to-back reqs at 0x0,0x4,0x8,0xC, each issued while o_fetch_ready=1 -> four valid pulses in order with words 0..3, exactly one AR handshake per request, araddr unchanged between AR and R handshakes.
- Req at 0x0000_0006 -> no arvalid ever, o_fetch_err=1 for exactly one cycle on the next cycle, o_fetch_ready stays 1.
- Req at 0x20, pulse i_flush in the ADDR cycle -> AR and R handshakes still complete, o_fetch_valid never asserts, o_fetch_instr unchanged; next req at 0x24 returns word[9] normally.
- Stub slave that never raises arready, TIMEOUT_CYCLES=8 -> arvalid drops and o_fetch_err pulses after 8 cycles in ADDR, then state is IDLE; same for a stub that never raises rvalid.
- Assert resetn=0 during DATA -> all outputs 0 immediately (asynchronous); after release, no stale o_fetch_valid, and a fresh req completes normally.

Source files
------------

// File: rtl/ifetch_axi_lite_master_if.sv
// AXI4-Lite read channel bundle (AR + R) between the fetch initiator and the
// instruction-memory read slave.
interface ifetch_axi_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );
endinterface

// File: rtl/ifetch_axi_lite_master.sv
// Single-outstanding AXI4-Lite read initiator for instruction fetch, with
// flush discard, misaligned-address rejection and a bus timeout.
module ifetch_axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_ready,
  output logic                  o_fetch_valid,
  output logic [DATA_WIDTH-1:0] o_fetch_instr,
  output logic                  o_fetch_err,
  input  logic                  i_flush,
  ifetch_axi_lite_master_if.master axi
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  err_q, err_d;
  logic                  discard_q, discard_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic ar_hs, r_hs, timeout_hit, drop;

  assign ar_hs       = arvalid_q && axi.arready;
  assign r_hs        = rready_q && axi.rvalid;
  assign timeout_hit = (cnt_q == CNT_LAST);
  // A flush arriving in the same cycle as the result still discards it.
  assign drop        = discard_q || i_flush;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    valid_d   = 1'b0;
    instr_d   = instr_q;
    err_d     = 1'b0;
    discard_d = discard_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_fetch_req) begin
          if (i_fetch_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            araddr_d  = i_fetch_addr;
            arvalid_d = 1'b1;
            cnt_d     = '0;
            discard_d = 1'b0;
            state_d   = ADDR;
          end
        end
      end

      ADDR: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (i_flush) discard_d = 1'b1;
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end else if (timeout_hit) begin
          arvalid_d = 1'b0;
          err_d     = !drop;
          discard_d = 1'b0;
          state_d   = IDLE;
        end
      end

      DATA: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (i_flush) discard_d = 1'b1;
        if (r_hs) begin
          rready_d  = 1'b0;
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!drop) begin
            instr_d = axi.rdata;
            valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          rready_d  = 1'b0;
          err_d     = !drop;
          discard_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_fetch_ready = (state_q == IDLE);
  assign o_fetch_valid = valid_q;
  assign o_fetch_instr = instr_q;
  assign o_fetch_err   = err_q;
  assign axi.araddr    = araddr_q;
  assign axi.arvalid   = arvalid_q;
  assign axi.rready    = rready_q;

endmodule
